// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue stage: op classes, register index, issue FSM state
// and the serialising-op predicate (also used by commit).
package issue_ctrl_pkg;

    typedef enum logic [2:0] {
        INSTR_ALU      = 3'd0,
        INSTR_LOAD     = 3'd1,
        INSTR_STORE    = 3'd2,
        INSTR_BRANCH   = 3'd3,
        INSTR_JUMP     = 3'd4,
        INSTR_MISC_MEM = 3'd5,
        INSTR_SYSTEM   = 3'd6,
        INSTR_INVAL    = 3'd7
    } instr_op;

    typedef logic [4:0] reg_idx;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } issue_state;

    localparam int NUM_REGS = 32;

    function automatic logic is_serialising(input instr_op op);
        return (op == INSTR_MISC_MEM) || (op == INSTR_SYSTEM) || (op == INSTR_INVAL);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register scoreboard: one pending bit per architectural register (x0 never pending),
// set on issue, cleared on writeback, cleared wholesale on flush; 3-port hazard lookup.
module issue_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_set_en,
    input  reg_idx              i_set_idx,
    input  logic                i_clr_en,
    input  reg_idx              i_clr_idx,
    input  logic                i_clr_all,
    input  logic [NUM_REGS-1:0] i_lookup_mask,
    input  reg_idx              i_rs1,
    input  reg_idx              i_rs2,
    input  reg_idx              i_rd,
    output logic                o_hazard
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_lookup;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_en) w_set[i_set_idx] = 1'b1;
        if (i_clr_en) w_clr[i_clr_idx] = 1'b1;
    end

    // Set is applied after clear so a same-index issue/writeback leaves the bit pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_pending <= '0;
        else if (i_clr_all) r_pending <= '0;
        else                r_pending <= ((r_pending & ~w_clr) | w_set) & ~NUM_REGS'(1);
    end

    assign w_lookup = r_pending & ~i_lookup_mask;
    assign o_hazard = w_lookup[i_rs1] | w_lookup[i_rs2] | w_lookup[i_rd];

endmodule

// File: rtl/issue_ctrl.sv
// Decode->execute issue gate: scoreboard hazards, in-flight limit, serialisation FSM, flush.
// Define ISSUE_WB_BYPASS_EN to let a dependent op issue in its producer's writeback cycle.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  instr_op          dec_op,
    input  reg_idx           dec_rs1,
    input  reg_idx           dec_rs2,
    input  reg_idx           dec_rd,
    output logic             iss_valid,
    input  logic             iss_ready,
    input  logic             wb_valid,
    input  reg_idx           wb_rd,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] inflight,
    output logic [31:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    issue_state          r_state;
    logic [CNT_W-1:0]    r_inflight;
    logic                r_busy;
    logic [31:0]         r_stall;

    logic                w_ser;
    logic                w_full;
    logic                w_hazard;
    logic                w_ok;
    logic                w_issue;
    logic                w_wb;
    logic                w_stall;
    logic [CNT_W-1:0]    w_inflight_nxt;
    logic [NUM_REGS-1:0] w_byp_mask;

    assign w_ser  = is_serialising(dec_op);
    assign w_full = (r_inflight == MAX_CNT);

    // rst gates the handshake so outputs drop immediately when reset asserts.
    assign w_ok = rst & (r_state == RUN) & !w_hazard & !w_full & !flush
                & (!w_ser | (r_inflight == '0));

    assign iss_valid = dec_valid & w_ok;
    assign dec_ready = iss_ready & w_ok;

    assign w_issue = iss_valid & iss_ready;
    assign w_wb    = wb_valid & !flush & (r_inflight != '0);
    assign w_stall = dec_valid & !dec_ready & !flush;

`ifdef ISSUE_WB_BYPASS_EN
    always_comb begin
        w_byp_mask = '0;
        if (wb_valid) w_byp_mask[wb_rd] = 1'b1;
    end
`else
    assign w_byp_mask = '0;
`endif

    issue_scoreboard u_sb (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_set_en      (w_issue),
        .i_set_idx     (dec_rd),
        .i_clr_en      (w_wb),
        .i_clr_idx     (wb_rd),
        .i_clr_all     (flush),
        .i_lookup_mask (w_byp_mask),
        .i_rs1         (dec_rs1),
        .i_rs2         (dec_rs2),
        .i_rd          (dec_rd),
        .o_hazard      (w_hazard)
    );

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (flush)                  w_inflight_nxt = '0;
        else if (w_issue && !w_wb)  w_inflight_nxt = r_inflight + CNT_ONE;
        else if (!w_issue && w_wb)  w_inflight_nxt = r_inflight - CNT_ONE;
    end

    // DRAIN and SERIAL both release on the edge that empties the back end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else if (flush) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_issue && w_ser)                          r_state <= SERIAL;
                    else if (dec_valid && w_ser && r_inflight != '0) r_state <= DRAIN;
                end
                DRAIN, SERIAL: begin
                    if (w_inflight_nxt == '0) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
            r_busy     <= 1'b0;
            r_stall    <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_busy     <= (w_inflight_nxt != '0);
            if (w_stall && (r_stall != '1)) r_stall <= r_stall + 32'd1;
        end
    end

    assign inflight     = r_inflight;
    assign busy         = r_busy;
    assign stall_cycles = r_stall;

`ifndef SYNTHESIS
    a_wb_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(wb_valid && !flush && (r_inflight == '0)));
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized bench for issue_ctrl against a queue-based model of in-flight instructions.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk, rst;
    logic          dec_valid, dec_ready;
    instr_op       dec_op;
    reg_idx        dec_rs1, dec_rs2, dec_rd;
    logic          iss_valid, iss_ready;
    logic          wb_valid;
    reg_idx        wb_rd;
    logic          flush;
    logic          busy;
    logic [CW-1:0] inflight;
    logic [31:0]   stall_cycles;

    issue_ctrl #(.MAX_INFLIGHT(MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_op       (dec_op),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy         (busy),
        .inflight     (inflight),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Model: every issued-but-not-retired instruction, plus a "waiting to drain" flag.
    typedef struct packed { logic [4:0] rd; logic ser; } ent_t;
    ent_t        q[$];
    bit          m_drain;
    int unsigned m_stall;
    bit          held;

    function automatic bit m_pend(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (BYP && wb_valid && wb_rd == idx) return 1'b0;
        foreach (q[i]) if (q[i].rd == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ser_in_flight();
        foreach (q[i]) if (q[i].ser) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_ser(input instr_op op);
        return op == INSTR_MISC_MEM || op == INSTR_SYSTEM || op == INSTR_INVAL;
    endfunction

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_op = INSTR_ALU;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        iss_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_drain = 1'b0;
        m_stall = 0;
        held    = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int wb_pct);
        for (int c = 0; c < n; c++) begin
            int k;
            bit ser, haz, running, ok, fire;
            int sz0;
            @(negedge clk);
            cyc++;
            chk("inflight", 32'(inflight), 32'(q.size()));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("stall_cycles", stall_cycles, m_stall);

            if (!held) begin
                dec_valid = ($urandom_range(0, 99) < 75);
                if ($urandom_range(0, 99) < 15) dec_op = instr_op'(3'($urandom_range(5, 7)));
                else                            dec_op = instr_op'(3'($urandom_range(0, 4)));
                dec_rs1 = 5'($urandom_range(0, 7));
                dec_rs2 = 5'($urandom_range(0, 7));
                dec_rd  = 5'($urandom_range(0, 7));
            end
            iss_ready = ($urandom_range(0, 99) < 80);
            flush     = ($urandom_range(0, 99) < 3);
            k = -1;
            if (q.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
                k = int'($urandom_range(0, q.size() - 1));
                wb_valid = 1'b1;
                wb_rd    = q[k].rd;
            end else begin
                wb_valid = 1'b0;
                wb_rd    = 5'($urandom_range(0, 31));
            end
            #1;

            ser     = op_ser(dec_op);
            haz     = m_pend(dec_rs1) | m_pend(dec_rs2) | m_pend(dec_rd);
            running = !m_drain && !m_ser_in_flight();
            ok      = running && !haz && (q.size() < MAX) && !flush && (!ser || q.size() == 0);
            chk("iss_valid", 32'(iss_valid), 32'(dec_valid && ok));
            chk("dec_ready", 32'(dec_ready), 32'(iss_ready && ok));

            fire = dec_valid && iss_ready && ok;
            if (dec_valid && !fire && !flush) m_stall++;
            if (flush) begin
                q.delete();
                m_drain = 1'b0;
            end else begin
                sz0 = q.size();
                if (k >= 0) q.delete(k);
                if (fire) q.push_back('{rd: dec_rd, ser: ser});
                if (m_drain) begin
                    if (q.size() == 0) m_drain = 1'b0;
                end else if (running && dec_valid && ser && sz0 != 0) begin
                    m_drain = 1'b1;
                end
            end
            held = dec_valid && !fire && !flush;
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        dec_valid = 1'b1; iss_ready = 1'b1;
        #1;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_dec_ready", 32'(dec_ready), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;

        run_cycles(600, 35);
        run_cycles(400, 8);
        run_cycles(600, 60);
        run_cycles(150, 5);

        // Asynchronous reset in the middle of a cycle with an issue offered.
        @(negedge clk);
        dec_valid = 1'b1; dec_op = INSTR_ALU; iss_ready = 1'b1;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = 5'd9; wb_valid = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("mid_rst_dec_ready", 32'(dec_ready), 32'd0);
        chk("mid_rst_inflight", 32'(inflight), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_stall", stall_cycles, 32'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        run_cycles(800, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue controller between the decode stage and execute.
- Holds a register scoreboard and an in-flight counter, and gates the decode→execute handshake on RAW/WAW hazards.
- Serialises MISC-MEM, SYSTEM and INVAL ops by draining the back end before and after they issue.
- Owns squash of its own state on pipeline flush.

Parameters:
MAX_INFLIGHT, 4, max issued-but-not-written-back instructions (≥1)
CNT_W, $clog2(MAX_INFLIGHT+1), width of in-flight counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
dec_valid  in  1  decoded instr present
dec_ready  out  1  decode may advance
dec_op  in  instr_op  op class of decoded instr
dec_rs1  in  5  source 1 index (0 = none)
dec_rs2  in  5  source 2 index (0 = none)
dec_rd  in  5  destination index (0 = none)
iss_valid  out  1  instr offered to execute
iss_ready  in  1  execute accepts
wb_valid  in  1  one retiring instr this cycle
wb_rd  in  5  its destination (0 = no write)
flush  in  1  squash all in-flight and decode
busy  out  1  inflight != 0
inflight  out  CNT_W  in-flight count
stall_cycles  out  32  saturating hazard-stall counter

Behaviour:
- Reset (rst low, async):
  - pending[31:1] = 0, inflight = 0, state = RUN, stall_cycles = 0.
  - Outputs iss_valid = 0, dec_ready = 0.
- hazard = pending[rs1] | pending[rs2] | pending[rd]. Index 0 never pending.
- full = (inflight == MAX_INFLIGHT).
- ser = dec_op ∈ {INSTR_MISC_MEM, INSTR_SYSTEM, INSTR_INVAL}.
- ok = state==RUN & !hazard & !full & !flush & (!ser | inflight==0).
- Combinational, zero latency:
  - iss_valid = dec_valid & ok.
  - dec_ready = iss_ready & ok.
  - No iss_valid depends on iss_ready.
- Issue event (iss_valid & iss_ready):
  - inflight += 1.
  - If rd != 0, set pending[rd].
  - If ser, state → SERIAL.
- Writeback event (wb_valid):
  - inflight -= 1.
  - If wb_rd != 0, clear pending[wb_rd].
  - Exactly one wb pulse per issued instr, in any order.
- Issue and wb in the same cycle: inflight unchanged. Same index: set wins over clear.
- wb_valid while inflight == 0 is a protocol error: counter holds at 0; simulation assertion fires.
- FSM:
  - RUN → DRAIN when dec_valid & ser & inflight != 0.
  - DRAIN: iss_valid = 0. → RUN when inflight reaches 0, so the serialising op issues the following cycle.
  - SERIAL: iss_valid = 0. → RUN when inflight reaches 0, i.e. the serialising op's wb.
- flush has priority over every same-cycle event:
  - pending cleared, inflight = 0, state = RUN.
  - Same-cycle issue and wb are ignored; iss_valid = dec_ready = 0.
- stall_cycles += 1 when dec_valid & !dec_ready & !flush; saturates at 2^32-1.
- No registered outputs other than busy, inflight, stall_cycles.

Optional Feature:
ISSUE_WB_BYPASS_EN
- Defined: pending bits used by hazard are masked by the current-cycle writeback (wb_valid & wb_rd == idx). A dependent instruction issues in the same cycle its producer writes back; the operand is forwarded downstream.
- Undefined: hazard uses registered pending only, costing one extra cycle per RAW/WAW dependency.

Decomposition:
- Shared types package: instr_op, reg_idx, and a new issue_state enum {RUN, DRAIN, SERIAL}.
- The is_serialising(instr_op) function also goes in the package, for reuse by the commit logic.
- One sub-module, issue_scoreboard: pending bit vector with set/clear/clear-all and a 3-port hazard lookup.
- FSM and counters stay in issue_ctrl.

Test Plan:
- Reset: drive rst low mid-issue → iss_valid = 0, inflight = 0, stall_cycles = 0 immediately, without waiting for a clock edge.
- RAW: issue rd=5; next cycle present rs1=5 → stalled, stall_cycles increments each cycle. wb_rd=5 → issues the same cycle with bypass, next cycle without.
- Full: MAX_INFLIGHT=4, issue 4 independent instrs with iss_ready=1 and no wb → 5th stalled, busy = 1, inflight = 4. One wb → 5th issues.
- Serialise: 2 in flight, present INSTR_SYSTEM → DRAIN, no issue until both wb. Issues next cycle → SERIAL. Younger instr held until SYSTEM's wb.
- Flush: 3 in flight with pending x1/x2/x3; assert flush together with wb_valid → inflight = 0, pending empty, state RUN. Next cycle rs1=x1 issues.
- Same-cycle set/clear: issue rd=7 while wb_rd=7 with bypass on → pending[7] = 1, inflight unchanged.
